// File: rtl/lc3_int_ctrl.sv
// LC-3 interrupt priority controller: latches, masks and arbitrates NUM_SRC
// interrupt sources against the current PSR priority and presents one
// request (INT/INTV/priority) to the control FSM until it is acknowledged.
module lc3_int_ctrl #(
    parameter int unsigned        NUM_SRC   = 8,
    parameter int unsigned        PRI_W     = 3,
    parameter logic [7:0]         VEC_BASE  = 8'h80,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = {NUM_SRC{1'b1}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC-1:0]       irq_in,
    input  logic [NUM_SRC-1:0]       ie_mask,
    input  logic [NUM_SRC*PRI_W-1:0] src_pri,
    input  logic [PRI_W-1:0]         cur_pri,
    input  logic                     int_ack,
    output logic                     int_req,
    output logic [7:0]               int_vec,
    output logic [PRI_W-1:0]         int_pri,
    output logic [NUM_SRC-1:0]       pending
);

    localparam int unsigned SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_SRC-1:0]   irq_prev_q;
    logic [NUM_SRC-1:0]   pending_q, pending_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [7:0]           vec_q, vec_d;
    logic [PRI_W-1:0]     pri_q, pri_d;
    logic                 req_q, req_d;

    logic [NUM_SRC-1:0]   elig;
    logic [NUM_SRC-1:0]   edge_det;
    logic [NUM_SRC-1:0]   clr;
    logic                 win_any;
    logic [SEL_W-1:0]     win_idx;
    logic [PRI_W-1:0]     win_pri;
    logic [7:0]           win_vec;
    logic                 elig_sel;
    logic                 ack_acc;

    // Ack only counts while a request is actually being presented
    assign ack_acc  = (state_q == REQ) && int_ack;
    assign win_vec  = VEC_BASE + 8'(win_idx);
    assign elig_sel = elig[sel_q];

    // Eligibility and arbitration: highest priority wins, ties to lowest index
    always_comb begin
        elig    = '0;
        win_any = 1'b0;
        win_idx = '0;
        win_pri = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            elig[i] = pending_q[i] & ie_mask[i] & (src_pri[i*PRI_W +: PRI_W] > cur_pri);
            if (elig[i] && (!win_any || (src_pri[i*PRI_W +: PRI_W] > win_pri))) begin
                win_any = 1'b1;
                win_idx = SEL_W'(i);
                win_pri = src_pri[i*PRI_W +: PRI_W];
            end
        end
    end

    // Pending next-state: edge sources latch (set beats clear), level sources follow input
    always_comb begin
        edge_det  = '0;
        clr       = '0;
        pending_d = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            edge_det[i] = irq_in[i] & ~irq_prev_q[i];
            clr[i]      = ack_acc && (sel_q == SEL_W'(i));
            if (EDGE_MASK[i]) begin
                pending_d[i] = (pending_q[i] & ~clr[i]) | edge_det[i];
            end else begin
                pending_d[i] = irq_in[i];
            end
        end
    end

    // FSM next-state and registered-output next values
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        vec_d   = vec_q;
        pri_d   = pri_q;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d = REQ;
                    sel_d   = win_idx;
                    vec_d   = win_vec;
                    pri_d   = win_pri;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_d = HOLD;
                end else if (!elig_sel) begin
                    state_d = IDLE;
                end else if (win_any && (win_pri > pri_q)) begin
                    sel_d = win_idx;
                    vec_d = win_vec;
                    pri_d = win_pri;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_d = (state_d == REQ);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: pending, edge history and presented request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
            sel_q      <= '0;
            vec_q      <= 8'h00;
            pri_q      <= '0;
            req_q      <= 1'b0;
        end else begin
            irq_prev_q <= irq_in;
            pending_q  <= pending_d;
            sel_q      <= sel_d;
            vec_q      <= vec_d;
            pri_q      <= pri_d;
            req_q      <= req_d;
        end
    end

    assign int_req = req_q;
    assign int_vec = vec_q;
    assign int_pri = pri_q;
    assign pending = pending_q;

endmodule

// File: doc/lc3_int_ctrl.md
Name: lc3_int_ctrl

Overview:
- Parametrised interrupt priority controller that drives the LC-3 control FSM's INT request and INTV vector. It replaces the tied-off INT = 0 in the datapath.
- Latches requests from NUM_SRC sources, in edge or level mode per source.
- Masks them per source and compares their priority against the current PSR priority.
- Holds one arbitrated request stable until the FSM acknowledges it.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..16).
- PRI_W, 3, priority field width; matches PSR[10:8].
- VEC_BASE, 8'h80, vector of source 0; source i gets VEC_BASE + i, truncated to 8 bits.
- EDGE_MASK, {NUM_SRC{1'b1}}, bit i = 1 makes source i edge-triggered; bit i = 0 makes it level-sensitive.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- irq_in  input  NUM_SRC  raw requests, synchronous to clk.
- ie_mask  input  NUM_SRC  per-source enable; 1 = enabled.
- src_pri  input  NUM_SRC*PRI_W  priority of source i in bits [i*PRI_W +: PRI_W].
- cur_pri  input  PRI_W  current PSR priority.
- int_ack  input  1  one-cycle pulse from the FSM when it loads the vector.
- int_req  output  1  INT to the FSM.
- int_vec  output  8  INTV; valid while int_req = 1.
- int_pri  output  PRI_W  priority of the presented source; the FSM loads it into PSR.
- pending  output  NUM_SRC  pending register, for debug and status reads.

Behaviour:
- Reset (async, rst = 1):
  - int_req = 0, int_vec = 8'h00, int_pri = 0, pending = 0.
  - irq_prev = 0, state = IDLE.
- Pending update, edge sources:
  - edge_i = irq_in[i] & ~irq_prev[i].
  - pending[i] <= (pending[i] & ~clr_i) | edge_i.
  - clr_i is true when int_ack is accepted for latched source i.
  - If edge_i and clr_i occur in the same cycle, set wins.
- Pending update, level sources:
  - pending[i] <= irq_in[i] every cycle; ack has no effect.
- irq_prev <= irq_in every cycle.
- Eligibility, combinational from registered pending:
  - elig_i = pending[i] & ie_mask[i] & (src_pri_i > cur_pri).
  - Comparison is unsigned and strict; equal priority is not eligible.
- Arbitration: winner is the eligible source with the highest src_pri; ties go to the lowest index.
- Latency: irq_in rises before edge E1 → pending set at E1 → int_req = 1 after E2 (2 cycles).
- State machine (state register, 2 bits):
  - IDLE: int_req = 0.
    - If any elig, go to REQ and latch sel = winner, int_vec = VEC_BASE + winner, int_pri = src_pri[winner].
  - REQ: int_req = 1; int_vec and int_pri are registered outputs.
    - If int_ack: accept it, clear pending[sel] (edge sources only), go to HOLD. Ack has precedence over everything else in the same cycle.
    - Else if elig_sel = 0 (withdrawn, masked, or cur_pri raised): go to IDLE, int_req = 0 next cycle.
    - Else if there is an eligible winner with src_pri strictly greater than latched int_pri: upgrade sel, int_vec and int_pri in place; stay in REQ.
    - Otherwise hold the outputs unchanged.
  - HOLD: int_req = 0 for exactly one cycle, so the FSM's PSR update lands before re-arbitration; then go to IDLE.
    - int_vec and int_pri keep their last values.
- int_ack outside REQ is ignored and clears nothing.
- Width rule: the vector adds modulo 256; pending has NUM_SRC bits; there are no other arithmetic widths.
- Reset mid-REQ: all outputs return to reset values immediately (async); any unacknowledged edge request is lost.

Test Plan:
- Reset and first request:
  - Stimulus: assert rst with irq_in = 8'hFF; release rst; ie_mask = 0.
  - Required: int_req = 0, pending = 8'hFF only after the first edge post-reset (edge sources with prev = 0), int_vec = 8'h00.
- Single edge source:
  - Stimulus: src 0, pri 4, cur_pri 0, 1-cycle irq_in[0] pulse.
  - Required: int_req = 1 two edges later with int_vec = 8'h80, int_pri = 4. Pulse int_ack → pending[0] = 0, int_req = 0 for the HOLD cycle, then IDLE with no re-request.
- Priority and tie-break:
  - Stimulus: src 2 pri 5, src 5 pri 5, src 7 pri 3, all pending together.
  - Required: int_vec = 8'h82. After ack, with cur_pri = 5, no request. After cur_pri = 2, the next request is 8'h85 (src 5, pri 5 > 2), not src 7.
- Upgrade and withdrawal:
  - Upgrade stimulus: in REQ on src 1 (pri 2), src 4 (pri 6) becomes pending.
  - Required: int_vec changes 8'h81 → 8'h84 with int_req held at 1.
  - Withdrawal stimulus: instead, mask src 1 (ie_mask[1] = 0).
  - Required: int_req drops next cycle and pending[1] remains 1.
- Level source, ack/edge collision and async reset:
  - Level stimulus: EDGE_MASK bit 3 = 0, irq_in[3] held high through ack.
  - Required: re-request with 8'h83 after HOLD.
  - Collision stimulus: a new edge on src 0 in the same cycle as its ack.
  - Required: pending[0] stays 1.
  - Async reset stimulus: assert rst between clock edges during REQ.
  - Required: int_req = 0 before the next rising edge.
